step_counter_arbiter: RTL and testbench

- Shares one WIDTH-bit step accumulator among NREQ requesters. Each requester asks to add its own step value.
- A round-robin arbiter picks one request, applies the add, and returns a one-cycle grant/ack.
- Serves as the sequencing controller for the team's incrementing-register datapath when several agents bump the same counter.

---
 rtl/step_counter_arbiter_pkg.sv | 32 +++
 rtl/step_counter_arbiter_if.sv | 38 +++
 rtl/step_counter_arbiter_rr_picker.sv | 44 ++++
 rtl/step_counter_arbiter.sv | 108 ++++++++++
 tb/tb_step_counter_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/step_counter_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// step_arb_pkg
//   Shared types and constants for the step_counter_arbiter block.
//   - state_e     : two-state sequencing FSM (IDLE, GRANT)
//   - DEF_*       : default NREQ / WIDTH / STEP_W values
//   - onehot_of() : index -> one-hot vector, sized for the largest NREQ (8)
//   Optional feature macro used by this block: STEP_ARB_SAT_EN
// ---------------------------------------------------------------------------
package step_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STEP_W = 8;

    // Largest supported requester count and the index width that covers it.
    localparam int MAX_NREQ = 8;
    localparam int IDX_W    = 3;

    // Callers truncate the result down to their own NREQ.
    function automatic logic [MAX_NREQ-1:0] onehot_of(input logic [IDX_W-1:0] idx);
        logic [MAX_NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/step_counter_arbiter_if.sv
// ---------------------------------------------------------------------------
// step_counter_arbiter_if
//   Request/ack bundle between the requesters and the shared accumulator.
//   Signals:
//     req      : per-requester request level, held until granted
//     step     : packed steps, requester i uses [i*STEP_W +: STEP_W]
//     grant    : one-hot, one-cycle ack (add already visible in value)
//     value    : accumulator contents
//     overflow : one-cycle pulse with the grant whose add carried out
//     busy     : high while the arbiter sits in GRANT
//   Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface step_counter_arbiter_if
    import step_arb_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
);

    logic [NREQ-1:0]        req;
    logic [NREQ*STEP_W-1:0] step;
    logic [NREQ-1:0]        grant;
    logic [WIDTH-1:0]       value;
    logic                   overflow;
    logic                   busy;

    modport master (
        output req, step,
        input  grant, value, overflow, busy
    );

    modport slave (
        input  req, step,
        output grant, value, overflow, busy
    );

endinterface

// File: rtl/step_counter_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Scans req_i starting at ptr_i and
//   wrapping modulo NREQ; winner_o is the first set bit found.
//   Ports:
//     req_i     : request vector
//     ptr_i     : scan start index (always < NREQ)
//     winner_o  : selected index (don't-care when any_req_o is low)
//     any_req_o : at least one request present
// ---------------------------------------------------------------------------
module rr_picker
    import step_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] winner_o,
    output logic             any_req_o
);

    // One extra bit so ptr + offset cannot wrap before the modulo fold.
    logic [PTR_W:0] idx;

    assign any_req_o = |req_i;

    // Walk offsets from farthest to nearest so the nearest set bit to ptr
    // is the last assignment and therefore the winner.
    always_comb begin
        winner_o = ptr_i;
        idx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_i} + (PTR_W + 1)'(k);
            if (idx >= (PTR_W + 1)'(NREQ)) begin
                idx = idx - (PTR_W + 1)'(NREQ);
            end
            if (req_i[idx[PTR_W-1:0]]) begin
                winner_o = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/step_counter_arbiter.sv
// ---------------------------------------------------------------------------
// step_counter_arbiter
//   Shares one WIDTH-bit accumulator among NREQ requesters. In IDLE a pending
//   request is picked round robin, its zero-extended step is added and a
//   one-cycle grant is registered; the FSM then spends one cycle in GRANT
//   (requests ignored) so requesters can drop req. One add per 2 cycles max.
//   Ports:
//     clock : system clock, rising edge
//     clear : synchronous active-high reset, wins over any request
//     bus   : step_counter_arbiter_if.slave (req, step, grant, value,
//             overflow, busy)
//   Optional feature: define STEP_ARB_SAT_EN to clamp value at all-ones on
//   carry-out instead of wrapping (overflow pulses either way).
// ---------------------------------------------------------------------------
module step_counter_arbiter
    import step_arb_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic                  clock,
    input  logic                  clear,
    step_counter_arbiter_if.slave bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q,   ptr_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              ovf_q,   ovf_d;

    logic [PTR_W-1:0]  winner;
    logic              any_req;
    logic [STEP_W-1:0] step_win;
    logic [WIDTH:0]    sum_w;
    logic              carry;
    logic [WIDTH-1:0]  value_add;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    // Winner's step, widened by one bit so the carry is visible.
    assign step_win = bus.step[winner*STEP_W +: STEP_W];
    assign sum_w    = {1'b0, value_q} + (WIDTH + 1)'(step_win);
    assign carry    = sum_w[WIDTH];

`ifdef STEP_ARB_SAT_EN
    assign value_add = carry ? '1 : sum_w[WIDTH-1:0];
`else
    assign value_add = sum_w[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        value_d = value_q;
        grant_d = '0;
        ovf_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = NREQ'(onehot_of(IDX_W'(winner)));
                    value_d = value_add;
                    ovf_d   = carry;
                    ptr_d   = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Requests are deliberately not looked at here.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            value_q <= '0;
            grant_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            value_q <= value_d;
            grant_q <= grant_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.value    = value_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q == GRANT);

endmodule

// File: tb/tb_step_counter_arbiter.sv
// ---------------------------------------------------------------------------
// tb_step_counter_arbiter
//   Directed bench. Main instance uses the default parameters (4 x 8-bit
//   steps, 32-bit value). A second, narrow instance (2 requesters, 9-bit
//   value) makes the carry-out reachable with 8-bit steps in a few grants.
// ---------------------------------------------------------------------------
module tb_step_counter_arbiter;

`ifdef STEP_ARB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clock = 1'b0;
    logic clear;

    always #5 clock = ~clock;

    step_counter_arbiter_if #(.NREQ(4), .WIDTH(32), .STEP_W(8)) bus  ();
    step_counter_arbiter_if #(.NREQ(2), .WIDTH(9),  .STEP_W(8)) sbus ();

    step_counter_arbiter #(.NREQ(4), .WIDTH(32), .STEP_W(8)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    step_counter_arbiter #(.NREQ(2), .WIDTH(9), .STEP_W(8)) dut_s (
        .clock (clock),
        .clear (clear),
        .bus   (sbus)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_m(input string tag, input logic [31:0] g, input logic [31:0] v,
                         input logic o, input logic b);
        chk({tag, ".grant"}, 64'(bus.grant),    64'(g));
        chk({tag, ".value"}, 64'(bus.value),    64'(v));
        chk({tag, ".ovf"},   64'(bus.overflow), 64'(o));
        chk({tag, ".busy"},  64'(bus.busy),     64'(b));
    endtask

    task automatic chk_s(input string tag, input logic [31:0] g, input logic [31:0] v,
                         input logic o, input logic b);
        chk({tag, ".grant"}, 64'(sbus.grant),    64'(g));
        chk({tag, ".value"}, 64'(sbus.value),    64'(v));
        chk({tag, ".ovf"},   64'(sbus.overflow), 64'(o));
        chk({tag, ".busy"},  64'(sbus.busy),     64'(b));
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int eg [9] = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
        int ev [9] = '{1, 1, 3, 3, 7, 7, 15, 15, 16};

        clear     = 1'b1;
        bus.req   = '0;
        bus.step  = '0;
        sbus.req  = '0;
        sbus.step = '0;
        #1;

        // clear beats a pending request
        bus.req  = 4'b0001;
        bus.step = 32'h0000_0003;
        cyc(); chk_m("rst0", 0, 0, 1'b0, 1'b0);
        cyc(); chk_m("rst1", 0, 0, 1'b0, 1'b0);
        clear = 1'b0;
        cyc(); chk_m("first", 'h1, 3, 1'b0, 1'b1);
        bus.req = 4'b0000;
        cyc(); chk_m("first_idle", 0, 3, 1'b0, 1'b0);

        // single requester, drop and re-raise, then hold
        bus.req = 4'b0001;
        cyc(); chk_m("single1", 'h1, 6, 1'b0, 1'b1);
        bus.req = 4'b0000;
        cyc(); chk_m("single1_idle", 0, 6, 1'b0, 1'b0);
        bus.req = 4'b0001;
        cyc(); chk_m("single2", 'h1, 9, 1'b0, 1'b1);
        cyc(); chk_m("single_gap", 0, 9, 1'b0, 1'b0);
        cyc(); chk_m("single3", 'h1, 12, 1'b0, 1'b1);
        bus.req = 4'b0000;
        cyc(); chk_m("single3_idle", 0, 12, 1'b0, 1'b0);

        // round robin with everyone requesting
        clear = 1'b1;
        cyc(); chk_m("rr_clr", 0, 0, 1'b0, 1'b0);
        clear    = 1'b0;
        bus.req  = 4'b1111;
        bus.step = {8'd8, 8'd4, 8'd2, 8'd1};
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk_m($sformatf("rr%0d", i), 32'(eg[i]), 32'(ev[i]), 1'b0, (eg[i] != 0));
        end
        bus.req = 4'b0000;
        cyc(); chk_m("rr_idle", 0, 16, 1'b0, 1'b0);

        // pointer fairness: ptr=2 after requester 1, then req=0011 -> 0 wins
        bus.req = 4'b0010;
        cyc(); chk_m("ptr_g1", 'h2, 18, 1'b0, 1'b1);
        bus.req = 4'b0000;
        cyc(); chk_m("ptr_idle", 0, 18, 1'b0, 1'b0);
        bus.req = 4'b0011;
        cyc(); chk_m("ptr_wrap", 'h1, 19, 1'b0, 1'b1);
        cyc(); chk_m("ptr_gap", 0, 19, 1'b0, 1'b0);
        cyc(); chk_m("ptr_next", 'h2, 21, 1'b0, 1'b1);
        bus.req = 4'b0000;
        cyc(); chk_m("ptr_end", 0, 21, 1'b0, 1'b0);

        // overflow on the narrow instance (max = 511)
        clear = 1'b1;
        cyc(); chk_s("s_rst", 0, 0, 1'b0, 1'b0);
        clear     = 1'b0;
        sbus.step = {8'd0, 8'd255};
        sbus.req  = 2'b01;
        cyc(); chk_s("s_pre1", 'h1, 255, 1'b0, 1'b1);
        sbus.req = 2'b00;
        cyc(); chk_s("s_pre1_idle", 0, 255, 1'b0, 1'b0);
        sbus.req = 2'b01;
        cyc(); chk_s("s_pre2", 'h1, 510, 1'b0, 1'b1);
        sbus.req = 2'b00;
        cyc();
        sbus.step = {8'd0, 8'd3};
        sbus.req  = 2'b01;
        cyc(); chk_s("s_ovf", 'h1, SAT ? 511 : 1, 1'b1, 1'b1);
        sbus.req = 2'b00;
        cyc(); chk_s("s_ovf_end", 0, SAT ? 511 : 1, 1'b0, 1'b0);
        sbus.step = {8'd1, 8'd0};
        sbus.req  = 2'b10;
        cyc(); chk_s("s_step1", 'h2, SAT ? 511 : 2, SAT, 1'b1);
        sbus.req = 2'b00;
        cyc(); chk_s("s_step1_end", 0, SAT ? 511 : 2, 1'b0, 1'b0);
        sbus.req = 2'b01;
        cyc(); chk_s("s_step0", 'h1, SAT ? 511 : 2, 1'b0, 1'b1);
        sbus.req = 2'b00;
        cyc();

        // clear while in GRANT aborts the pulse
        sbus.step = {8'd0, 8'd5};
        sbus.req  = 2'b01;
        cyc(); chk_s("s_pre_clr", 'h1, SAT ? 511 : 7, SAT, 1'b1);
        clear    = 1'b1;
        sbus.req = 2'b00;
        cyc(); chk_s("s_clr", 0, 0, 1'b0, 1'b0);
        chk_m("m_clr", 0, 0, 1'b0, 1'b0);
        clear = 1'b0;
        cyc(); chk_s("s_after_clr", 0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
